// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ctrl
//  Purpose  : UART transmit sequencer. Accepts one byte per valid/ready
//             handshake and serialises it LSB first onto a registered TX pin:
//             start bit, DATA_BITS data bits, optional parity, STOP_BITS stops.
//             The bit-period counter restarts at acceptance, so every bit
//             lasts exactly CLK_DIV clocks from the first start-bit cycle.
//  Options  : define UART_TX_PARITY_EN to add a parity bit (PARITY_ODD selects
//             odd parity) between the data and stop bits.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int CLK_DIV   = 434,
    parameter int DIV_WIDTH = 9,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_srst,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    // Frame sequencer states
    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_start  = 3'd1;
    localparam logic [2:0] c_data   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_parity = 3'd3;
`endif
    localparam logic [2:0] c_stop   = 3'd4;

    // Bit index covers both data bits (up to 9) and stop bits
    localparam int                   c_idx_w     = 4;
    localparam logic [DIV_WIDTH-1:0] c_cnt_last  = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [c_idx_w-1:0]   c_data_last = c_idx_w'(DATA_BITS - 1);
    localparam logic [c_idx_w-1:0]   c_stop_last = c_idx_w'(STOP_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;
    logic [c_idx_w-1:0]   idx_q,   idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q,    tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q,   par_d;
`endif

    logic w_bit_end;
    logic w_last_stop;

    assign w_bit_end   = (cnt_q == c_cnt_last);
    assign w_last_stop = (state_q == c_stop) && w_bit_end && (idx_q == c_stop_last);

    assign o_ready = (state_q == c_idle) && !i_srst;
    assign o_busy  = (state_q != c_idle);
    assign o_tx    = tx_q;
    // An abort in the final stop cycle suppresses the completion pulse
    assign o_done  = w_last_stop && !i_srst;

    // Next-state, bit timing and line-level computation; o_tx is registered
    // so the pin value is decided one cycle ahead from the upcoming state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        if (state_q != c_idle) begin
            cnt_d = w_bit_end ? '0 : cnt_q + 1'b1;
        end

        if (i_srst) begin
            state_d = c_idle;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = '0;
            tx_d    = 1'b1;
        end else begin
            case (state_q)
                c_idle: begin
                    if (i_valid) begin
                        state_d = c_start;
                        cnt_d   = '0;
                        idx_d   = '0;
                        shift_d = i_data;
                        tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                        // Parity is fixed from the captured byte, before any shifting
                        par_d   = (^i_data) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                c_start: begin
                    if (w_bit_end) begin
                        state_d = c_data;
                        tx_d    = shift_q[0];
                    end
                end
                c_data: begin
                    if (w_bit_end) begin
                        shift_d = shift_q >> 1;
                        if (idx_q == c_data_last) begin
                            idx_d = '0;
`ifdef UART_TX_PARITY_EN
                            state_d = c_parity;
                            tx_d    = par_q;
`else
                            state_d = c_stop;
                            tx_d    = 1'b1;
`endif
                        end else begin
                            idx_d = idx_q + 1'b1;
                            tx_d  = shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_parity: begin
                    if (w_bit_end) begin
                        state_d = c_stop;
                        tx_d    = 1'b1;
                    end
                end
`endif
                c_stop: begin
                    tx_d = 1'b1;
                    if (w_bit_end) begin
                        if (idx_q == c_stop_last) begin
                            state_d = c_idle;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = c_idle;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    // State registers with asynchronous return to an idle-high line
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= c_idle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_ctrl
//  Purpose  : Self-checking bench for uart_tx_ctrl. Expected line waveforms
//             are built per frame as a list of bit levels (start, data LSB
//             first, optional parity, stops), each held CLK_DIV cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int STOP_BITS  = 2;
    localparam int PARITY_ODD = 0;
`else
    localparam int STOP_BITS  = 1;
`endif

    logic       clk;
    logic       i_nrst;
    logic       i_srst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    int checks   = 0;
    int failures = 0;

    uart_tx_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .DIV_WIDTH (3),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD(PARITY_ODD)
`endif
    ) u_dut (
        .i_clk  (clk),
        .i_nrst (i_nrst),
        .i_srst (i_srst),
        .i_data (i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_tx   (o_tx),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Idle line: high, not busy, ready, no completion
    task automatic check_idle(input string tag);
        check_eq({tag, "_tx"},    o_tx,    1);
        check_eq({tag, "_busy"},  o_busy,  0);
        check_eq({tag, "_ready"}, o_ready, 1);
        check_eq({tag, "_done"},  o_done,  0);
    endtask

    // Checks a whole frame cycle by cycle, starting at the negedge of its
    // first start-bit cycle. Inputs are scrambled during the frame; on the
    // final cycle i_valid/i_data are set to nv/nd. Returns at the first idle
    // negedge after the frame.
    task automatic frame_body(input logic [7:0] b, input logic nv, input logic [7:0] nd);
        bit eb[16];
        int nb;
        int len;
        eb[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) eb[1 + i] = b[i];
        nb = 1 + DATA_BITS;
`ifdef UART_TX_PARITY_EN
        eb[nb] = (^b) ^ (PARITY_ODD != 0);
        nb++;
`endif
        for (int s = 0; s < STOP_BITS; s++) begin
            eb[nb] = 1'b1;
            nb++;
        end
        len = nb * CLK_DIV;
        for (int k = 0; k < len; k++) begin
            check_eq("frame_tx",    o_tx,    eb[k / CLK_DIV]);
            check_eq("frame_done",  o_done,  (k == len - 1));
            check_eq("frame_busy",  o_busy,  1);
            check_eq("frame_ready", o_ready, 0);
            if (k == len - 1) begin
                i_valid = nv;
                i_data  = nd;
            end else begin
                i_valid = 1'($urandom_range(0, 1));
                i_data  = 8'($urandom);
            end
            @(negedge clk);
        end
        check_idle("post_frame");
    endtask

    // Presents a byte from idle and checks the resulting frame
    task automatic send_frame(input logic [7:0] b);
        i_data  = b;
        i_valid = 1'b1;
        @(negedge clk);
        frame_body(b, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b1;
        logic [7:0] b2;
        int         gap;

        i_nrst  = 1'b0;
        i_srst  = 1'b0;
        i_data  = 8'h00;
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_tx",   o_tx,   1);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        i_nrst = 1'b1;
        @(negedge clk);
        check_idle("after_rst");

        // Directed frame
        send_frame(8'hA5);

        // Back-to-back with i_valid held: second frame starts after one idle cycle
        send_frame_b2b: begin
            i_data  = 8'h01;
            i_valid = 1'b1;
            @(negedge clk);
            frame_body(8'h01, 1'b1, 8'hFF);
            @(negedge clk);
            frame_body(8'hFF, 1'b0, 8'h00);
        end

        // Synchronous abort during data bit 3
        i_data  = 8'h3C;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        for (int k = 0; k < CLK_DIV * 4 + 1; k++) begin
            check_eq("abort_pre_tx", o_tx, (k < CLK_DIV) ? 1'b0 : b_bit(8'h3C, k / CLK_DIV - 1));
            @(negedge clk);
        end
        i_srst  = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h99;
        @(negedge clk);
        check_eq("abort_tx",    o_tx,    1);
        check_eq("abort_busy",  o_busy,  0);
        check_eq("abort_ready", o_ready, 0);
        check_eq("abort_done",  o_done,  0);
        @(negedge clk);
        check_eq("abort_hold_busy",  o_busy,  0);
        check_eq("abort_hold_ready", o_ready, 0);
        check_eq("abort_hold_tx",    o_tx,    1);
        i_srst  = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        check_idle("after_abort");
        send_frame(8'hC3);

        // Asynchronous reset in the middle of a start bit
        i_data  = 8'h5A;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        check_eq("nrst_pre_tx", o_tx, 0);
        #2;
        i_nrst = 1'b0;
        #1;
        check_eq("nrst_async_tx",   o_tx,   1);
        check_eq("nrst_async_busy", o_busy, 0);
        check_eq("nrst_async_done", o_done, 0);
        @(negedge clk);
        i_nrst = 1'b1;
        @(negedge clk);
        check_idle("after_nrst");
        send_frame(8'h96);

        // Randomized traffic: random bytes, random idle gaps, some back-to-back pairs
        for (int n = 0; n < 12; n++) begin
            b1  = 8'($urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check_idle("gap");
            end
            if ($urandom_range(0, 1) == 1) begin
                b2      = 8'($urandom);
                i_data  = b1;
                i_valid = 1'b1;
                @(negedge clk);
                frame_body(b1, 1'b1, b2);
                @(negedge clk);
                frame_body(b2, 1'b0, 8'h00);
            end else begin
                send_frame(b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic b_bit(input logic [7:0] b, input int i);
        return b[i];
    endfunction

endmodule
`default_nettype wire
